// File: rtl/routing_lbdr_3d_core.sv
// LBDR output-port selector for one router of a 3D mesh NoC.
// It decodes the destination into mesh coordinates and compares them with this node's
// coordinates to get the direction flags. Each output port is then gated by its
// connectivity bit, its routing bits and the turn bits. The port mask is registered.
module routing_lbdr_3d_core #(
  parameter int unsigned NodeId                       = 0,
  parameter int unsigned NodeIdWidth                  = 6,
  parameter int unsigned NumberOfRows                 = 3,
  parameter int unsigned NumberOfColumns              = 4,
  parameter int unsigned NumberOfLayers               = 5,
  parameter int unsigned NumberOfLBDRRoutingBits      = 24,
  parameter int unsigned NumberOfLBDRConnectivityBits = 6,
  parameter int unsigned NumberOfLBDRTurnBits         = 6
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NumberOfLBDRRoutingBits-1:0]      lbdr_routing_bits_i,
  input  logic [NumberOfLBDRConnectivityBits-1:0] lbdr_connectivity_bits_i,
  input  logic [NumberOfLBDRTurnBits-1:0]         lbdr_turn_bits_i,
  input  logic [NodeIdWidth-1:0]                  destination_node_id_i,
  output logic [5:0]                              valid_ports_out_o
);

  localparam int unsigned LayerSize = NumberOfColumns * NumberOfRows;
  localparam int unsigned NumNodes  = LayerSize * NumberOfLayers;

  // Coordinates of this router, fixed at elaboration.
  localparam int unsigned XCur = NodeId % NumberOfColumns;
  localparam int unsigned YCur = (NodeId % LayerSize) / NumberOfColumns;
  localparam int unsigned ZCur = NodeId / LayerSize;

  // Routing bits, named after the port they gate and the direction they test.
  logic w_rne, w_rnw, w_rnu, w_rnd;
  logic w_ren, w_res, w_reu, w_red;
  logic w_rwn, w_rws, w_rwu, w_rwd;
  logic w_rse, w_rsw, w_rsu, w_rsd;
  logic w_rue, w_ruw, w_run, w_rus;
  logic w_rde, w_rdw, w_rdn, w_rds;

  assign {w_rne, w_rnw, w_rnu, w_rnd} = lbdr_routing_bits_i[23:20];
  assign {w_ren, w_res, w_reu, w_red} = lbdr_routing_bits_i[19:16];
  assign {w_rwn, w_rws, w_rwu, w_rwd} = lbdr_routing_bits_i[15:12];
  assign {w_rse, w_rsw, w_rsu, w_rsd} = lbdr_routing_bits_i[11:8];
  assign {w_rue, w_ruw, w_run, w_rus} = lbdr_routing_bits_i[7:4];
  assign {w_rde, w_rdw, w_rdn, w_rds} = lbdr_routing_bits_i[3:0];

  // Connectivity bits: 1 means the link on that side exists.
  logic w_cn, w_ce, w_cw, w_cs, w_cu, w_cd;
  assign {w_cn, w_ce, w_cw, w_cs, w_cu, w_cd} = lbdr_connectivity_bits_i[5:0];

  // Turn bits. Tab allows a hop in dimension b while hops in dimension a remain.
  logic w_tyx, w_tzx, w_txy, w_tzy, w_txz, w_tyz;
  assign {w_tyx, w_tzx, w_txy, w_tzy, w_txz, w_tyz} = lbdr_turn_bits_i[5:0];

  // Destination decode, with constant divisors only.
  logic [31:0] w_dst;
  logic [31:0] w_xd;
  logic [31:0] w_yd;
  logic [31:0] w_zd;
  logic        w_dst_in_range;

  assign w_dst          = 32'(destination_node_id_i);
  assign w_xd           = w_dst % NumberOfColumns;
  assign w_yd           = (w_dst % LayerSize) / NumberOfColumns;
  assign w_zd           = w_dst / LayerSize;
  assign w_dst_in_range = (w_dst < NumNodes);

  // Direction flags. North is increasing y and up is increasing z.
  logic w_e, w_w, w_n, w_s, w_u, w_d;
  logic w_x, w_y, w_z;

  assign w_e = (w_xd > XCur);
  assign w_w = (w_xd < XCur);
  assign w_n = (w_yd > YCur);
  assign w_s = (w_yd < YCur);
  assign w_u = (w_zd > ZCur);
  assign w_d = (w_zd < ZCur);
  assign w_x = w_e | w_w;
  assign w_y = w_n | w_s;
  assign w_z = w_u | w_d;

  // Routing-bit gating for each port. A term is open when its direction is not
  // pending or when the matching routing bit is set.
  logic w_route_n, w_route_s, w_route_e, w_route_w, w_route_u, w_route_d;

  assign w_route_n = (~w_e | w_rne) & (~w_w | w_rnw) & (~w_u | w_rnu) & (~w_d | w_rnd);
  assign w_route_s = (~w_e | w_rse) & (~w_w | w_rsw) & (~w_u | w_rsu) & (~w_d | w_rsd);
  assign w_route_e = (~w_n | w_ren) & (~w_s | w_res) & (~w_u | w_reu) & (~w_d | w_red);
  assign w_route_w = (~w_n | w_rwn) & (~w_s | w_rws) & (~w_u | w_rwu) & (~w_d | w_rwd);
  assign w_route_u = (~w_e | w_rue) & (~w_w | w_ruw) & (~w_n | w_run) & (~w_s | w_rus);
  assign w_route_d = (~w_e | w_rde) & (~w_w | w_rdw) & (~w_n | w_rdn) & (~w_s | w_rds);

  // Turn gating for each dimension of travel.
  logic w_turn_y, w_turn_x, w_turn_z;

  assign w_turn_y = (~w_x | w_txy) & (~w_z | w_tzy);
  assign w_turn_x = (~w_y | w_tyx) & (~w_z | w_tzx);
  assign w_turn_z = (~w_x | w_txz) & (~w_y | w_tyz);

  // Port mask before registering. An out-of-range id yields no port. A destination
  // equal to this node sets no direction flag, so it also yields no port.
  logic [5:0] w_ports;

  // Combine connectivity, direction, routing and turn gating for each port.
  always_comb begin
    w_ports = 6'b000000;
    if (w_dst_in_range) begin
      w_ports[5] = w_cn & w_n & w_route_n & w_turn_y;
      w_ports[4] = w_ce & w_e & w_route_e & w_turn_x;
      w_ports[3] = w_cw & w_w & w_route_w & w_turn_x;
      w_ports[2] = w_cs & w_s & w_route_s & w_turn_y;
      w_ports[1] = w_cu & w_u & w_route_u & w_turn_z;
      w_ports[0] = w_cd & w_d & w_route_d & w_turn_z;
    end
  end

  logic [5:0] r_valid_ports;

  // Register the mask on every edge. Reset clears it asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_ports <= 6'b000000;
    end else begin
      r_valid_ports <= w_ports;
    end
  end

  assign valid_ports_out_o = r_valid_ports;

endmodule

// File: tb/tb_routing_lbdr_3d_core.sv
// Bench for routing_lbdr_3d_core: 4x3x5 mesh, node 29.
// The expected masks come from a table-driven model of the LBDR rules and from a
// plain dimension-order XYZ reference.
module tb_routing_lbdr_3d_core;

  localparam int Cols   = 4;
  localparam int Rows   = 3;
  localparam int Layers = 5;
  localparam int Nodes  = Cols * Rows * Layers;
  localparam int Me     = 29;

  localparam logic [23:0] XyzRoute = 24'h3FF300;
  localparam logic [5:0]  XyzTurn  = 6'b110100;

  logic        clk;
  logic        rst_n;
  logic [23:0] route_bits;
  logic [5:0]  conn_bits;
  logic [5:0]  turn_bits;
  logic [5:0]  dst;
  logic [5:0]  ports;

  int n_vec;
  int n_err;

  routing_lbdr_3d_core #(
    .NodeId                      (Me),
    .NodeIdWidth                 (6),
    .NumberOfRows                (Rows),
    .NumberOfColumns             (Cols),
    .NumberOfLayers              (Layers),
    .NumberOfLBDRRoutingBits     (24),
    .NumberOfLBDRConnectivityBits(6),
    .NumberOfLBDRTurnBits        (6)
  ) u_dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .lbdr_routing_bits_i     (route_bits),
    .lbdr_connectivity_bits_i(conn_bits),
    .lbdr_turn_bits_i        (turn_bits),
    .destination_node_id_i   (dst),
    .valid_ports_out_o       (ports)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Directions are indexed N,E,W,S,U,D = 0..5. Mask bit = 5 - index.
  int dir_dim [6] = '{1, 0, 0, 1, 2, 2};
  // Routing bit position used by port p for pending direction q, or -1 when none.
  int rpos [6][6] = '{
    '{-1, 23, 22, -1, 21, 20},
    '{19, -1, -1, 18, 17, 16},
    '{15, -1, -1, 14, 13, 12},
    '{-1, 11, 10, -1,  9,  8},
    '{ 5,  7,  6,  4, -1, -1},
    '{ 1,  3,  2,  0, -1, -1}
  };
  // Turn bit position for "remaining dim a, hop in dim b".
  int tpos [3][3] = '{
    '{-1, 3, 1},
    '{ 5, -1, 0},
    '{ 4, 2, -1}
  };

  function automatic void coords(input int id, output int c[3]);
    c[0] = id % Cols;
    c[1] = (id % (Cols * Rows)) / Cols;
    c[2] = id / (Cols * Rows);
  endfunction

  function automatic logic [5:0] ref_ports(input int d, input logic [23:0] r,
                                           input logic [5:0] c, input logic [5:0] t);
    int   cur [3];
    int   des [3];
    int   delta [3];
    logic need [6];
    logic ok;
    logic [5:0] res;
    res = '0;
    if (d >= Nodes) return res;
    coords(Me, cur);
    coords(d, des);
    for (int k = 0; k < 3; k++) delta[k] = des[k] - cur[k];
    need[0] = delta[1] > 0;
    need[1] = delta[0] > 0;
    need[2] = delta[0] < 0;
    need[3] = delta[1] < 0;
    need[4] = delta[2] > 0;
    need[5] = delta[2] < 0;
    for (int p = 0; p < 6; p++) begin
      ok = c[5-p] && need[p];
      for (int q = 0; q < 6; q++)
        if (need[q] && rpos[p][q] >= 0 && !r[rpos[p][q]]) ok = 1'b0;
      for (int a = 0; a < 3; a++)
        if (a != dir_dim[p] && delta[a] != 0 && !t[tpos[a][dir_dim[p]]]) ok = 1'b0;
      res[5-p] = ok;
    end
    return res;
  endfunction

  // Plain dimension-order XYZ routing: finish X, then Y, then Z.
  function automatic logic [5:0] xyz_ports(input int d);
    int cur [3];
    int des [3];
    if (d >= Nodes || d == Me) return 6'b000000;
    coords(Me, cur);
    coords(d, des);
    if (des[0] > cur[0]) return 6'b010000;
    if (des[0] < cur[0]) return 6'b001000;
    if (des[1] > cur[1]) return 6'b100000;
    if (des[1] < cur[1]) return 6'b000100;
    if (des[2] > cur[2]) return 6'b000010;
    return 6'b000001;
  endfunction

  // Connectivity of this node from the mesh borders.
  function automatic logic [5:0] border_conn();
    int cur [3];
    coords(Me, cur);
    return {cur[1] < Rows - 1, cur[0] < Cols - 1, cur[0] > 0, cur[1] > 0,
            cur[2] < Layers - 1, cur[2] > 0};
  endfunction

  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Drive one vector at the falling edge and sample the registered result just after
  // the next rising edge.
  task automatic apply(input logic [5:0] d, input logic [23:0] r, input logic [5:0] c,
                       input logic [5:0] t);
    @(negedge clk);
    dst        = d;
    route_bits = r;
    conn_bits  = c;
    turn_bits  = t;
    @(posedge clk);
    #1;
  endtask

  logic [5:0] bc;
  logic [5:0] exp_v;
  logic [23:0] rr;
  logic [5:0]  rc;
  logic [5:0]  rt;
  logic [5:0]  rd;
  int          dsts [9];
  logic [5:0]  dexp [9];

  initial begin
    n_vec      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    dst        = 6'd30;
    route_bits = XyzRoute;
    turn_bits  = XyzTurn;
    bc         = border_conn();
    conn_bits  = bc;

    #12;
    check("reset_state", ports, 6'b000000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_release_hold", ports, 6'b000000);

    // Listed examples from the XYZ configuration.
    dsts = '{28, 30, 33, 25, 5, 53, 29, 0, 59};
    dexp = '{6'b001000, 6'b010000, 6'b100000, 6'b000100, 6'b000001,
             6'b000010, 6'b000000, 6'b001000, 6'b010000};
    for (int i = 0; i < 9; i++) begin
      apply(6'(dsts[i]), XyzRoute, bc, XyzTurn);
      check($sformatf("xyz_example_dst%0d", dsts[i]), ports, dexp[i]);
    end

    // Full sweep against dimension order and the rule model.
    for (int i = 0; i < Nodes; i++) begin
      apply(6'(i), XyzRoute, bc, XyzTurn);
      check($sformatf("xyz_sweep_dst%0d", i), ports, xyz_ports(i));
      check($sformatf("model_sweep_dst%0d", i), ports, ref_ports(i, XyzRoute, bc, XyzTurn));
    end

    // Latency: the output follows the new destination only after the next edge.
    apply(6'd28, XyzRoute, bc, XyzTurn);
    check("latency_before", ports, 6'b001000);
    @(negedge clk);
    dst = 6'd30;
    #1;
    check("latency_hold", ports, 6'b001000);
    @(posedge clk);
    #1;
    check("latency_after", ports, 6'b010000);

    // Asynchronous reset in the middle of traffic.
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async", ports, 6'b000000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_release_wait", ports, 6'b000000);
    @(posedge clk);
    #1;
    check("reset_first_result", ports, 6'b010000);

    // Adaptive configuration: east and up both admissible.
    apply(6'd54, XyzRoute | 24'h000080, bc, XyzTurn | 6'b000010);
    check("adaptive_dst54", ports, 6'b010010);

    // Missing east link.
    apply(6'd30, XyzRoute, bc & 6'b101111, XyzTurn);
    check("conn_mask_ce0", ports, 6'b000000);

    // Out-of-range destinations.
    apply(6'd63, XyzRoute, bc, XyzTurn);
    check("out_of_range_63", ports, 6'b000000);
    apply(6'd60, 24'hFFFFFF, 6'h3F, 6'h3F);
    check("out_of_range_60", ports, 6'b000000);

    // Random configurations and destinations, one vector per cycle.
    for (int i = 0; i < 400; i++) begin
      rd = 6'($urandom_range(0, 63));
      rr = 24'($urandom);
      rc = 6'($urandom);
      rt = 6'($urandom);
      if (i % 4 == 0) begin
        rc = 6'h3F;
        rt = 6'h3F;
      end
      exp_v = ref_ports(int'(rd), rr, rc, rt);
      apply(rd, rr, rc, rt);
      check($sformatf("random_%0d_dst%0d", i, rd), ports, exp_v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
